// File: rtl/stopwatch_ctl.sv
// stopwatch_ctl
// Controller for a two-digit BCD countdown stopwatch. It drives an external
// down counter through one-cycle tick/load strobes, blinks an LED bank when
// the count reaches 00, and can optionally freeze the display on a lap.
// Optional lap-hold feature: define STOPWATCH_LAP_EN to enable it.
module stopwatch_ctl #(
   parameter int         TICK_DIV = 100000000,
   parameter logic [3:0] INIT_D1  = 4'd3,
   parameter logic [3:0] INIT_D0  = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pb_start,
   input  logic        pb_lap,
   input  logic [3:0]  dig1_in,
   input  logic [3:0]  dig0_in,
   output logic        cnt_tick,
   output logic        cnt_load,
   output logic [3:0]  load_d1,
   output logic [3:0]  load_d0,
   output logic [3:0]  disp_d1,
   output logic [3:0]  disp_d0,
   output logic [1:0]  state,
   output logic [14:0] light
);

   localparam int             PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [PW-1:0]  r_presc;
   logic [PW-1:0]  w_prescNext;
   logic [14:0]    r_light;
   logic [14:0]    w_lightNext;
   logic           w_zero;
   logic           w_wrap;
   logic           w_load;
   logic           w_tick;

   assign w_zero = (dig1_in == 4'd0) && (dig0_in == 4'd0);
   assign w_wrap = (r_presc == PRESC_MAX);

   // State, prescaler and LED bank registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_presc <= '0;
         r_light <= '0;
      end else begin
         r_state <= w_nextState;
         r_presc <= w_prescNext;
         r_light <= w_lightNext;
      end
   end

   // Next-state, prescaler, blink and strobe decisions; the zero test on the
   // live digits wins over pb_start in RUN so the count can never underflow
   always_comb begin
      w_nextState = r_state;
      w_prescNext = r_presc;
      w_lightNext = r_light;
      w_load      = 1'b0;
      w_tick      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_prescNext = '0;
            if (pb_start) begin
               w_nextState = ST_RUN;
            end else if (pb_lap) begin
               w_load = 1'b1;
            end
         end
         ST_RUN: begin
            w_prescNext = w_wrap ? '0 : r_presc + PW'(1);
            w_tick      = w_wrap && !w_zero;
            if (w_zero) begin
               w_nextState = ST_DONE;
               w_prescNext = '0;
               w_lightNext = '1;
            end else if (pb_start) begin
               w_nextState = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (pb_start) begin
               w_nextState = ST_RUN;
            end else if (pb_lap) begin
               w_load      = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         ST_DONE: begin
            w_prescNext = w_wrap ? '0 : r_presc + PW'(1);
            if (w_wrap) begin
               w_lightNext = ~r_light;
            end
            if (pb_start || pb_lap) begin
               w_load      = 1'b1;
               w_nextState = ST_IDLE;
               w_prescNext = '0;
               w_lightNext = '0;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Strobes are forced low while reset is held; load always beats tick
   assign cnt_load = w_load && !rst;
   assign cnt_tick = w_tick && !w_load && !rst;
   assign load_d1  = INIT_D1;
   assign load_d0  = INIT_D0;
   assign state    = r_state;
   assign light    = r_light;

`ifdef STOPWATCH_LAP_EN
   logic       r_lapHold;
   logic [3:0] r_lapD1;
   logic [3:0] r_lapD0;

   // Lap hold toggles on pb_lap in RUN and is dropped whenever the counter is reloaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lapHold <= 1'b0;
         r_lapD1   <= 4'd0;
         r_lapD0   <= 4'd0;
      end else if (w_load) begin
         r_lapHold <= 1'b0;
      end else if ((r_state == ST_RUN) && pb_lap && !pb_start && !w_zero) begin
         r_lapHold <= !r_lapHold;
         if (!r_lapHold) begin
            r_lapD1 <= dig1_in;
            r_lapD0 <= dig0_in;
         end
      end
   end

   assign disp_d1 = r_lapHold ? r_lapD1 : dig1_in;
   assign disp_d0 = r_lapHold ? r_lapD0 : dig0_in;
`else
   assign disp_d1 = dig1_in;
   assign disp_d0 = dig0_in;
`endif

endmodule

// File: tb/tb_stopwatch_ctl.sv
// tb_stopwatch_ctl
// Drives stopwatch_ctl (TICK_DIV=4, reload 30) together with a BCD down
// counter, and compares every cycle against a behavioural stopwatch model.
// Build with STOPWATCH_LAP_EN defined to exercise the lap-hold feature.
module tb_stopwatch_ctl;

   localparam int TDIV = 4;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAPEN = 1'b1;
`else
   localparam bit LAPEN = 1'b0;
`endif

   localparam int MI = 0;
   localparam int MR = 1;
   localparam int MP = 2;
   localparam int MD = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pb_start = 1'b0;
   logic        pb_lap = 1'b0;
   logic [3:0]  d1 = 4'd4;
   logic [3:0]  d0 = 4'd5;
   logic        cnt_tick;
   logic        cnt_load;
   logic [3:0]  load_d1;
   logic [3:0]  load_d0;
   logic [3:0]  disp_d1;
   logic [3:0]  disp_d0;
   logic [1:0]  state;
   logic [14:0] light;

   int nChecks = 0;
   int nFail   = 0;
   bit chkEn   = 1'b0;

   // Behavioural model: counter value as a plain integer
   int mState = MI;
   int mVal   = 45;
   int mPhase = 0;
   int mBlink = 0;
   bit mHold  = 1'b0;
   int mLap   = 0;

   stopwatch_ctl #(.TICK_DIV(TDIV), .INIT_D1(4'd3), .INIT_D0(4'd0)) dut (
      .clk(clk), .rst(rst), .pb_start(pb_start), .pb_lap(pb_lap),
      .dig1_in(d1), .dig0_in(d0), .cnt_tick(cnt_tick), .cnt_load(cnt_load),
      .load_d1(load_d1), .load_d0(load_d0), .disp_d1(disp_d1), .disp_d0(disp_d0),
      .state(state), .light(light)
   );

   always #5 clk = ~clk;

   // External BCD down counter driven by the controller strobes
   always @(posedge clk) begin
      if (cnt_load) begin
         d1 <= load_d1;
         d0 <= load_d0;
      end else if (cnt_tick) begin
         if (d0 == 4'd0) begin
            d0 <= 4'd9;
            d1 <= d1 - 4'd1;
         end else begin
            d0 <= d0 - 4'd1;
         end
      end
   end

   function automatic int liveVal();
      return int'(d1) * 10 + int'(d0);
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on each clock edge from the button rules
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mState = MI;
         mHold  = 1'b0;
         mPhase = 0;
         mBlink = 0;
      end else begin
         case (mState)
            MI: begin
               if (pb_start) begin
                  mState = MR;
                  mPhase = 0;
               end else if (pb_lap) begin
                  mVal = 30;
               end
            end
            MR: begin
               if (mVal == 0) begin
                  mState = MD;
                  mBlink = 0;
               end else begin
                  if (!pb_start && pb_lap && LAPEN) begin
                     if (!mHold) mLap = mVal;
                     mHold = !mHold;
                  end
                  if (mPhase == TDIV - 1) mVal = mVal - 1;
                  mPhase = (mPhase + 1) % TDIV;
                  if (pb_start) mState = MP;
               end
            end
            MP: begin
               if (pb_start) begin
                  mState = MR;
               end else if (pb_lap) begin
                  mState = MI;
                  mVal   = 30;
                  mHold  = 1'b0;
               end
            end
            default: begin
               if (pb_start || pb_lap) begin
                  mState = MI;
                  mVal   = 30;
                  mHold  = 1'b0;
               end else begin
                  mBlink++;
               end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      int expLoad;
      int expTick;
      int expLight;
      int shown;
      if (chkEn && !rst) begin
         expLoad = ((mState == MI || mState == MP) && pb_lap && !pb_start) ||
                   (mState == MD && (pb_start || pb_lap));
         expTick = (mState == MR) && (mPhase == TDIV - 1) && (mVal != 0);
         expLight = (mState == MD && ((mBlink / TDIV) % 2 == 0)) ? 32'h7FFF : 0;
         shown = mHold ? mLap : mVal;
         checkOutput("state", int'(state), mState);
         checkOutput("cnt_load", int'(cnt_load), expLoad);
         checkOutput("cnt_tick", int'(cnt_tick), expTick);
         checkOutput("light", int'(light), expLight);
         checkOutput("disp_d1", int'(disp_d1), shown / 10);
         checkOutput("disp_d0", int'(disp_d0), shown % 10);
         checkOutput("load_digits", int'({load_d1, load_d0}), 32'h30);
      end
   end

   // Advance one edge, then apply the given buttons for the coming cycle
   task automatic applyStimulus(input bit s, input bit l);
      @(posedge clk);
      #1;
      pb_start = s;
      pb_lap   = l;
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      #1 rst = 1'b1;
      #2;
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_load", int'(cnt_load), 0);
      checkOutput("reset_tick", int'(cnt_tick), 0);
      checkOutput("reset_light", int'(light), 0);
      checkOutput("reset_disp", int'({disp_d1, disp_d0}), 32'h45);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      chkEn = 1'b1;

      // Reload from IDLE
      applyStimulus(1'b0, 1'b1);
      checkOutput("idle_lap_load", int'(cnt_load), 1);
      checkOutput("idle_lap_state", int'(state), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_load_once", int'(cnt_load), 0);
      checkOutput("idle_digits_30", int'({disp_d1, disp_d0}), 32'h30);

      // Start and first ticks
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("run_state", int'(state), 1);
         checkOutput("first_tick_timing", int'(cnt_tick), (k == 3) ? 1 : 0);
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("digits_29", int'({disp_d1, disp_d0}), 32'h29);

      // Pause at prescaler 2, hold for 10 cycles, resume
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("pause_state", int'(state), 2);
         checkOutput("pause_no_tick", int'(cnt_tick), 0);
      end
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("resume_tick", int'(cnt_tick), 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("digits_28", int'({disp_d1, disp_d0}), 32'h28);

`ifdef STOPWATCH_LAP_EN
      n = 0;
      while (liveVal() != 25 && n < 100) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      if (n >= 100) checkOutput("reach_25_timeout", liveVal(), 25);
      applyStimulus(1'b0, 1'b1);
      n = 0;
      while (liveVal() != 22 && n < 100) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("lap_hold_25", int'({disp_d1, disp_d0}), 32'h25);
         n++;
      end
      if (n >= 100) checkOutput("reach_22_timeout", liveVal(), 22);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("lap_release_22", int'({disp_d1, disp_d0}), 32'h22);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("both_buttons_pause", int'(state), 2);
      checkOutput("both_buttons_no_lap", int'({disp_d1, disp_d0}), liveVal() / 10 * 16 + liveVal() % 10);
      applyStimulus(1'b1, 1'b0);
`else
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("lap_ignored_state", int'(state), 1);
      checkOutput("lap_ignored_disp", int'({disp_d1, disp_d0}), liveVal() / 10 * 16 + liveVal() % 10);
`endif

      // Run to 00 and watch the blink
      n = 0;
      while (state != 2'b11 && n < 1000) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      if (n >= 1000) checkOutput("reach_done_timeout", int'(state), 3);
      checkOutput("done_digits_00", int'({d1, d0}), 0);
      checkOutput("done_light_on", int'(light), 32'h7FFF);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkOutput("done_light_off", int'(light), 0);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkOutput("done_light_on_again", int'(light), 32'h7FFF);
      applyStimulus(1'b1, 1'b0);
      checkOutput("done_exit_load", int'(cnt_load), 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("done_exit_state", int'(state), 0);
      checkOutput("done_exit_light", int'(light), 0);
      checkOutput("done_exit_digits", int'({disp_d1, disp_d0}), 32'h30);

      // Asynchronous reset between edges while a tick is due
      applyStimulus(1'b1, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkOutput("tick_before_reset", int'(cnt_tick), 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_reset_state", int'(state), 0);
      checkOutput("async_reset_tick", int'(cnt_tick), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Randomized buttons with occasional mid-cycle resets
      for (int i = 0; i < 900; i++) begin
         applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      end
      applyStimulus(1'b0, 1'b0);
      @(posedge clk);
      chkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctl.md
STOPWATCH_CTL -- requirements
Module: stopwatch_ctl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per count tick (minimum 2).
REQ-002 The block SHALL have parameter INIT_D1, default 4'd3, meaning the BCD tens digit loaded on reload.
REQ-003 The block SHALL have parameter INIT_D0, default 4'd0, meaning the BCD ones digit loaded on reload.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port pb_start, input, 1 bit: one-cycle start/pause pulse.
REQ-007 The block SHALL have port pb_lap, input, 1 bit: one-cycle lap/clear pulse.
REQ-008 The block SHALL have ports dig1_in and dig0_in, input, 4 bits each: live BCD digits from the down counter.
REQ-009 The block SHALL have port cnt_tick, output, 1 bit: one-cycle decrement strobe to the counter.
REQ-010 The block SHALL have port cnt_load, output, 1 bit: one-cycle reload strobe to the counter.
REQ-011 The block SHALL have ports load_d1 and load_d0, output, 4 bits each: constants INIT_D1 and INIT_D0.
REQ-012 The block SHALL have ports disp_d1 and disp_d0, output, 4 bits each: digits to display.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-014 The block SHALL have port light, output, 15 bits: LED bank.

Function
REQ-015 Transitions: IDLE->RUN on pb_start; RUN->PAUSE on pb_start; PAUSE->RUN on pb_start; RUN->DONE when dig1_in==0 and dig0_in==0.
REQ-016 pb_lap in IDLE SHALL pulse cnt_load one cycle; state stays IDLE.
REQ-017 pb_lap in PAUSE SHALL pulse cnt_load, clear the lap hold and go to IDLE.
REQ-018 pb_start or pb_lap in DONE SHALL pulse cnt_load, clear the lap hold, clear light and go to IDLE.
REQ-019 Prescaler: counts 0..TICK_DIV-1 only in RUN; cleared on IDLE->RUN; held (not cleared) in PAUSE; wraps to 0 after TICK_DIV-1.
REQ-020 cnt_tick SHALL be asserted in the RUN cycle where the prescaler equals TICK_DIV-1, unless the live digits are 00; first tick comes TICK_DIV cycles after RUN entry.
REQ-021 Zero detection SHALL be registered: DONE is entered the cycle after 00 is sampled in RUN; no cnt_tick is issued at 00 (no underflow).
REQ-022 In DONE the prescaler SHALL keep running and light SHALL toggle between all-ones and all-zeros every TICK_DIV cycles, starting at all-ones on DONE entry; light SHALL be 0 in all other states.
REQ-023 pb_start and pb_lap in the same cycle: pb_start SHALL take effect and pb_lap SHALL be ignored.
REQ-024 With no lap held, disp_d1/disp_d0 SHALL equal dig1_in/dig0_in combinationally.
REQ-025 cnt_tick and cnt_load SHALL never be asserted in the same cycle; cnt_load has priority.

Reset
REQ-026 While rst=1: state=IDLE, prescaler=0, cnt_tick=0, cnt_load=0, light=0, lap hold cleared; disp follows the live digits.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL take effect immediately, without waiting for a clock edge; after release the block waits in IDLE for pb_start.

Configuration
REQ-028 With macro STOPWATCH_LAP_EN defined, pb_lap in RUN SHALL toggle a lap hold. When setting the hold, the live digits are captured into lap registers and disp shows the lap registers. When clearing it, disp returns to the live digits. Counting continues in both cases.
REQ-029 Without STOPWATCH_LAP_EN, pb_lap in RUN SHALL be ignored, no lap registers SHALL exist, and disp SHALL always equal the live digits.

Verification (TICK_DIV=4, INIT=30, behavioural BCD down-counter model attached)
REQ-030 Reset, then pb_lap in IDLE -> cnt_load is high for one cycle, digits read 30, state=00.
REQ-031 pb_start -> state=01; first cnt_tick 4 cycles later, then one every 4 cycles; digits go 29, 28, ...
REQ-032 pb_start at prescaler=2, wait 10 cycles, pb_start again -> no ticks while in PAUSE; next tick 1 cycle after resume.
REQ-033 Run down to 00 -> no tick at 00; state=11 the next cycle; light=7FFF, then 0000 after 4 cycles, then 7FFF again; pb_start -> cnt_load, state=00, light=0.
REQ-034 With STOPWATCH_LAP_EN, pb_lap at 25 -> disp holds 25 while the live digits reach 22; pb_lap again -> disp shows 22. pb_start and pb_lap together in RUN -> PAUSE only, no lap change.
REQ-035 rst pulsed mid-RUN between clock edges -> state=00 and cnt_tick=0 before the next edge.
